// File: rtl/fnn_layer_sequencer_if.sv
// Signal bundle between a layer sequencer, its neuron array and the
// neighbouring layers. The sequencer takes the master side.
interface fnn_layer_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 30
);
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH-1:0]             neuron_in;
  logic                              neuron_in_valid;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out;
  logic [NUM_NEURONS-1:0]            neuron_outvalid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              busy;
  logic                              timeout_err;
  logic                              err_clr;

  modport master (
    input  in_data, in_valid, neuron_out, neuron_outvalid, out_ready, err_clr,
    output in_ready, neuron_in, neuron_in_valid, out_data, out_valid, busy, timeout_err
  );

  modport slave (
    output in_data, in_valid, neuron_out, neuron_outvalid, out_ready, err_clr,
    input  in_ready, neuron_in, neuron_in_valid, out_data, out_valid, busy, timeout_err
  );
endinterface

// File: rtl/fnn_layer_sequencer.sv
// Buffers one activation vector, bursts it to every neuron of the layer,
// gathers the neuron results and streams them on to the next layer.
module fnn_layer_sequencer #(
  parameter int NUM_INPUTS  = 30,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 64
) (
  input logic                   clk,
  input logic                   rst,
  fnn_layer_sequencer_if.master bus
);
  localparam int MAX_LEN = (NUM_INPUTS > NUM_NEURONS) ? NUM_INPUTS : NUM_NEURONS;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IN  = CW'(NUM_INPUTS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, WAIT, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [NUM_NEURONS-1:0]  mask_q, mask_d, capture;
  logic [DATA_WIDTH-1:0]   ibuf [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]   obuf [NUM_NEURONS];

  logic                    in_ready_q, in_ready_d;
  logic                    nin_valid_q, nin_valid_d;
  logic [DATA_WIDTH-1:0]   nin_q, nin_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    busy_q, busy_d;
  logic                    terr_q, terr_d;

  logic                    accept, out_hs, timed_out;
  logic [CW-1:0]           obuf_idx;

  assign accept = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    mask_d    = '0;
    capture   = '0;
    timed_out = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (cnt_q == LAST_IN) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            state_d = FILL;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      STREAM: begin
        if (cnt_q == LAST_IN) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        // Only the first pulse per neuron is captured; repeats are dropped.
        capture = bus.neuron_outvalid & ~mask_q;
        mask_d  = mask_q | bus.neuron_outvalid;
        tmo_d   = tmo_q + TW'(1);
        if (&mask_d) begin
          state_d = DRAIN;
        end else if (tmo_d == TW'(TIMEOUT)) begin
          state_d   = IDLE;
          timed_out = 1'b1;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (cnt_q == LAST_OUT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead; the drain word is
  // prefetched from the index that will be current after this edge.
  always_comb begin
    in_ready_d  = (state_d == IDLE) || (state_d == FILL);
    busy_d      = (state_d != IDLE);
    nin_valid_d = (state_q == STREAM);
    nin_d       = '0;
    out_valid_d = (state_q == DRAIN) && !(out_hs && (cnt_q == LAST_OUT));
    out_data_d  = out_data_q;
    obuf_idx    = out_hs ? cnt_q + CW'(1) : cnt_q;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (nin_valid_d && (CW'(k) == cnt_q)) nin_d = ibuf[k];
    end
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (out_valid_d && (CW'(n) == obuf_idx)) out_data_d = obuf[n];
    end
    terr_d = timed_out | (terr_q & ~bus.err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      mask_q      <= '0;
      in_ready_q  <= 1'b0;
      nin_valid_q <= 1'b0;
      nin_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      mask_q      <= mask_d;
      in_ready_q  <= in_ready_d;
      nin_valid_q <= nin_valid_d;
      nin_q       <= nin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
    end
  end

  // NOTE: the buffers are not reset; each word is written before it is read,
  // and leaving reset off lets them map onto plain storage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (accept && (CW'(k) == cnt_q)) ibuf[k] <= bus.in_data;
    end
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (capture[n]) obuf[n] <= bus.neuron_out[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.neuron_in       = nin_q;
  assign bus.neuron_in_valid = nin_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.busy            = busy_q;
  assign bus.timeout_err     = terr_q;
endmodule

// File: tb/tb_fnn_layer_sequencer.sv
// Directed bench for fnn_layer_sequencer with a 4-input, 3-neuron layer and a
// short timeout; the neuron array is played by hand-timed outvalid pulses.
module tb_fnn_layer_sequencer;
  localparam int NI = 4;
  localparam int NN = 3;
  localparam int DW = 16;
  localparam int TO = 8;

  typedef logic [NI-1:0][DW-1:0] ivec_t;
  typedef logic [NN-1:0][DW-1:0] ovec_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   span;

  fnn_layer_sequencer_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) bus ();

  fnn_layer_sequencer #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 10) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Ends #1 after the edge of the last accept (cycle 0).
  task automatic send_vector(input ivec_t v, input logic gap);
    for (int i = 0; i < NI; i++) begin
      send_word(v[i]);
      if (gap && i < NI - 1) tick();
    end
    check("fill_done_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill_done_busy", 32'(bus.busy), 32'd1);
    check("fill_done_nvalid", 32'(bus.neuron_in_valid), 32'd0);
  endtask

  task automatic stream_check(input ivec_t v);
    for (int i = 0; i < NI; i++) begin
      tick();
      check($sformatf("stream_valid%0d", i), 32'(bus.neuron_in_valid), 32'd1);
      check($sformatf("stream_data%0d", i), 32'(bus.neuron_in), 32'(v[i]));
    end
    tick();
    check("stream_end_valid", 32'(bus.neuron_in_valid), 32'd0);
  endtask

  task automatic pulse(input logic [NN-1:0] m, input ovec_t vals);
    bus.neuron_outvalid = m;
    bus.neuron_out      = vals;
    tick();
    bus.neuron_outvalid = '0;
    bus.neuron_out      = {NN{16'hDEAD}};
  endtask

  // pat gives out_ready for each cycle out_valid is seen (LSB first, then 1s).
  task automatic drain(input logic [5:0] pat, input ovec_t exp, output int vcycles);
    int j = 0;
    int n = 0;
    int k = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    vcycles = 0;
    while (j < NN && n < 40) begin
      if (bus.out_valid) begin
        vcycles++;
        bus.out_ready = (k < 6) ? pat[k] : 1'b1;
        k++;
        check("drain_in_ready", 32'(bus.in_ready), 32'd0);
        if (stalled) check("drain_hold", 32'(bus.out_data), 32'(held));
        if (bus.out_ready) begin
          check($sformatf("drain_word%0d", j), 32'(bus.out_data), 32'(exp[j]));
          j++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.out_data;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", 32'(j), 32'(NN));
    check("drain_end_valid", 32'(bus.out_valid), 32'd0);
    check("drain_end_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_nominal(input ivec_t v, input ovec_t o);
    send_vector(v, 1'b0);
    stream_check(v);
    tick();
    tick();
    pulse('1, o);
    check("complete_no_valid_yet", 32'(bus.out_valid), 32'd0);
    drain(6'b111111, o, span);
    check("nominal_consecutive", 32'(span), 32'(NN));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_nvalid"}, 32'(bus.neuron_in_valid), 32'd0);
    check({tag, "_nin"}, 32'(bus.neuron_in), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_terr"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.in_data         = '0;
    bus.in_valid        = 1'b0;
    bus.neuron_out      = {NN{16'hDEAD}};
    bus.neuron_outvalid = '0;
    bus.out_ready       = 1'b0;
    bus.err_clr         = 1'b0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Nominal vector 1,2,3,4 -> 0x10,0x20,0x30
    run_nominal({16'd4, 16'd3, 16'd2, 16'd1}, {16'h30, 16'h20, 16'h10});

    // Stray pulses while idle must be ignored
    pulse('1, {NN{16'hEEEE}});
    check("stray_busy", 32'(bus.busy), 32'd0);
    check("stray_out_valid", 32'(bus.out_valid), 32'd0);

    // Skewed arrival with a duplicate on neuron 1
    send_vector({16'hA4, 16'hA3, 16'hA2, 16'hA1}, 1'b0);
    stream_check({16'hA4, 16'hA3, 16'hA2, 16'hA1});
    pulse(3'b100, {16'h002C, 16'hDEAD, 16'hDEAD});
    pulse(3'b010, {16'hDEAD, 16'h0021, 16'hDEAD});
    pulse(3'b010, {16'hDEAD, 16'h0099, 16'hDEAD});
    check("skew_wait_valid", 32'(bus.out_valid), 32'd0);
    check("skew_wait_busy", 32'(bus.busy), 32'd1);
    tick();
    pulse(3'b001, {16'hDEAD, 16'hDEAD, 16'h000A});
    check("skew_no_valid_yet", 32'(bus.out_valid), 32'd0);
    drain(6'b111111, {16'h002C, 16'h0021, 16'h000A}, span);

    // Input gaps during fill, then backpressure 0,0,1,0,1,1 on drain
    send_vector({16'd6, 16'd7, 16'd8, 16'd9}, 1'b1);
    stream_check({16'd6, 16'd7, 16'd8, 16'd9});
    tick();
    tick();
    pulse('1, {16'h13, 16'h12, 16'h11});
    drain(6'b110100, {16'h13, 16'h12, 16'h11}, span);
    check("bp_valid_cycles", 32'(span), 32'd6);

    // Timeout: neuron 1 never answers; WAIT entered at edge 4, abort at edge 12
    send_vector({16'd1, 16'd1, 16'd1, 16'd1}, 1'b0);
    stream_check({16'd1, 16'd1, 16'd1, 16'd1});
    pulse(3'b101, {16'h55, 16'hDEAD, 16'h66});
    for (int c = 7; c <= 11; c++) begin
      tick();
      check($sformatf("tmo_pending_terr_c%0d", c), 32'(bus.timeout_err), 32'd0);
      check($sformatf("tmo_pending_valid_c%0d", c), 32'(bus.out_valid), 32'd0);
    end
    tick();
    check("tmo_terr", 32'(bus.timeout_err), 32'd1);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    check("tmo_in_ready", 32'(bus.in_ready), 32'd1);
    check("tmo_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("tmo_sticky", 32'(bus.timeout_err), 32'd1);
    check("tmo_after_valid", 32'(bus.out_valid), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_clr", 32'(bus.timeout_err), 32'd0);

    // Reset during STREAM cycle 2, then a clean vector
    send_vector({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
    tick();
    tick();
    check("mid_stream_valid", 32'(bus.neuron_in_valid), 32'd1);
    check("mid_stream_data", 32'(bus.neuron_in), 32'd2);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    run_nominal({16'd8, 16'd7, 16'd6, 16'd5}, {16'h0150, 16'h0140, 16'h0130});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fnn_layer_sequencer.md
# fnn_layer_sequencer

Sequences one fully connected layer of the FNN accelerator. It buffers an incoming activation vector, broadcasts it as one contiguous burst to every neuron of the layer, and collects each neuron's registered output as its `outvalid` pulses. It then streams the result vector to the next layer over a valid/ready handshake. It sits between consecutive layer arrays and owns the `myinput`/`myinputValid` drive of all neurons in its layer.

## Interface
- `NUM_INPUTS`, 30: words per input vector; equals the neurons' `numWeight`.
- `NUM_NEURONS`, 30: neurons in the layer, which is also the number of output words.
- `DATA_WIDTH`, 16: activation word width.
- `TIMEOUT`, 64: maximum WAIT cycles before the block aborts.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in DATA_WIDTH: input activation word.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts an input word.
- `neuron_in` out DATA_WIDTH: broadcast activation; drives every neuron's `myinput`.
- `neuron_in_valid` out 1: broadcast valid; drives every neuron's `myinputValid`.
- `neuron_out` in NUM_NEURONS*DATA_WIDTH: concatenated neuron outputs; neuron n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- `neuron_outvalid` in NUM_NEURONS: per-neuron `outvalid` pulses.
- `out_data` out DATA_WIDTH: result word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the result word.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_err` out 1: sticky abort flag.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- All outputs are registered.
- Reset values: `in_ready`=0, `neuron_in_valid`=0, `neuron_in`=0, `out_valid`=0, `out_data`=0, `busy`=0, `timeout_err`=0.
- Reset drives the state to IDLE and clears all counters and the capture mask. Buffer contents are don't-care after reset.
- States are IDLE, FILL, STREAM, WAIT and DRAIN.
- IDLE and FILL:
  - `in_ready`=1.
  - A word is accepted when `in_valid & in_ready`; word k is written to ibuf[k].
  - The first accepted word moves IDLE to FILL.
  - On the NUM_INPUTS-th accept, `in_ready` drops at the same edge and the state moves to STREAM.
  - If NUM_INPUTS=1, IDLE moves directly to STREAM.
- STREAM:
  - `neuron_in_valid`=1 for exactly NUM_INPUTS consecutive cycles, with `neuron_in`=ibuf[i] on the i-th cycle.
  - No gaps are allowed, because the neurons detect end-of-vector from the falling edge of valid.
  - After the last word, the state moves to WAIT and `neuron_in_valid`=0.
- WAIT:
  - A per-neuron capture mask starts at 0.
  - When `neuron_outvalid[n]` is seen with mask[n]=0, the block latches `neuron_out` slice n into obuf[n] and sets mask[n].
  - Repeat pulses for a neuron whose mask bit is already set are ignored.
  - When the mask is all ones, including pulses registered in the current cycle, the state moves to DRAIN on the next cycle.
  - A WAIT cycle counter increments every cycle. When it reaches TIMEOUT with the mask incomplete, `timeout_err` is set, the vector is discarded, and the state moves to IDLE.
- `neuron_outvalid` is ignored outside WAIT.
- DRAIN:
  - `out_valid`=1 and `out_data`=obuf[j].
  - j advances only on `out_valid & out_ready`. `out_data` holds stable while `out_valid & !out_ready`.
  - The handshake on word NUM_NEURONS-1 returns the state to IDLE; `out_valid` drops at that edge.
- `timeout_err` clears on `err_clr`. If a new timeout occurs in the same cycle as `err_clr`, set wins.
- The block takes no new input until DRAIN completes; there is no overlap between fill and drain.

## Timing
- Cycle 0 is the edge of the last input accept. `neuron_in_valid` is high in cycles 1..NUM_INPUTS.
- The neurons pulse `outvalid` about 4 cycles after their last valid input. The block must tolerate any arrival order and skew within TIMEOUT.
- WAIT to DRAIN: `out_valid` rises 1 cycle after mask completion.
- The first `out_data` word is accepted no earlier than NUM_INPUTS+6 cycles after the last input accept.
- `in_ready` reasserts 1 cycle after the final output handshake.
- Widths:
  - ibuf and obuf are DATA_WIDTH wide.
  - Counters are $clog2(max(NUM_INPUTS, NUM_NEURONS)+1) bits wide.
  - The timeout counter is $clog2(TIMEOUT+1) bits wide.
  - No counter wraps.
- Reset asserted mid-STREAM forces `neuron_in_valid`=0 on the next edge. The neurons are reset by the same `rst`.

## Test plan
- Nominal:
  - Setup: NUM_INPUTS=4, NUM_NEURONS=3, `out_ready`=1, inputs 1,2,3,4.
  - Required: `neuron_in_valid` high for exactly 4 cycles carrying 1,2,3,4.
  - Model neurons pulse `outvalid` at +4 with values 0x10,0x20,0x30.
  - Required: the outputs 0x10,0x20,0x30 are emitted on 3 consecutive cycles.
- Skewed and duplicate pulses:
  - Stimulus: neuron 2 pulses first, neuron 0 pulses last, and neuron 1 pulses twice with 0x21 then 0x99.
  - Required: output order is by neuron index and word 1 = 0x21.
- Backpressure:
  - Stimulus: `out_ready` toggles 0,0,1,0,1,1.
  - Required: `out_data` is held while stalled, no word is duplicated or dropped, and `in_ready`=0 throughout.
- Input gaps:
  - Stimulus: `in_valid` is deasserted between words during FILL.
  - Required: the STREAM burst is still 4 contiguous cycles.
- Timeout:
  - Stimulus: neuron 1 never pulses, TIMEOUT=8.
  - Required: `timeout_err`=1 8 cycles after WAIT entry, the state returns to IDLE, and `out_valid` is never asserted.
  - Stimulus: `err_clr` pulses.
  - Required: `timeout_err` clears.
- Reset mid-operation:
  - Stimulus: `rst` asserted during STREAM cycle 2.
  - Required: all outputs are at reset values the next cycle, `in_ready`=1 one cycle after `rst` deasserts, and a subsequent vector completes correctly.
